// File: rtl/plab5_mcore_mem_req_cmsg_unpack.sv
`default_nettype none
// ============================================================================
// Module   : plab5_mcore_mem_req_cmsg_unpack
// Brief    : Two-entry val/rdy queue that unpacks memory-request control
//            messages {type, opaque, addr, len} and tags them with a domain.
//            Optional build macro PLAB5_MCORE_MEM_REQ_CMSG_UNPACK_SCRUB_EN
//            clears dequeued entries and masks outputs while the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module plab5_mcore_mem_req_cmsg_unpack #(
    parameter int p_opaque_nbits = 8,
    parameter int p_addr_nbits   = 32,
    parameter int p_data_nbits   = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_domain,
    input  logic [3+p_opaque_nbits+p_addr_nbits+$clog2(p_data_nbits/8)-1:0] in_msg,
    input  logic                                  in_val,
    output logic                                  in_rdy,
    output logic                                  out_domain,
    output logic [2:0]                            out_type,
    output logic [p_opaque_nbits-1:0]             out_opaque,
    output logic [p_addr_nbits-1:0]               out_addr,
    output logic [$clog2(p_data_nbits/8)-1:0]     out_len,
    output logic [$clog2(p_data_nbits/8):0]       out_nbytes,
    output logic                                  out_val,
    input  logic                                  out_rdy
);

    localparam int c_TYPE_NBITS = 3;
    localparam int c_LEN_NBITS  = $clog2(p_data_nbits / 8);
    localparam int c_MSG_NBITS  = c_TYPE_NBITS + p_opaque_nbits + p_addr_nbits + c_LEN_NBITS;
    localparam logic [c_LEN_NBITS:0] c_NBYTES_FULL = (c_LEN_NBITS + 1)'(p_data_nbits / 8);

    // Each entry is {domain, msg}; the domain bit sits above the message MSB.
    logic [1:0][c_MSG_NBITS:0] entry_q, entry_d;
    logic                      enq_ptr_q, enq_ptr_d;
    logic                      deq_ptr_q, deq_ptr_d;
    logic [1:0]                count_q, count_d;

    logic                      w_enq_fire;
    logic                      w_deq_fire;
    logic [c_MSG_NBITS:0]      w_head;

    assign in_rdy     = (count_q != 2'd2) && reset;
    assign out_val    = (count_q != 2'd0);
    assign w_enq_fire = in_val && in_rdy;
    assign w_deq_fire = out_val && out_rdy;

    always_comb begin
        entry_d   = entry_q;
        enq_ptr_d = enq_ptr_q;
        deq_ptr_d = deq_ptr_q;
        count_d   = count_q;

        if (w_deq_fire) begin
`ifdef PLAB5_MCORE_MEM_REQ_CMSG_UNPACK_SCRUB_EN
            entry_d[deq_ptr_q] = '0;
`endif
            deq_ptr_d = ~deq_ptr_q;
        end

        // Enqueue is applied last so a write always wins over a scrub.
        if (w_enq_fire) begin
            entry_d[enq_ptr_q] = {in_domain, in_msg};
            enq_ptr_d          = ~enq_ptr_q;
        end

        case ({w_enq_fire, w_deq_fire})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry_q   <= '0;
            enq_ptr_q <= 1'b0;
            deq_ptr_q <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            entry_q   <= entry_d;
            enq_ptr_q <= enq_ptr_d;
            deq_ptr_q <= deq_ptr_d;
            count_q   <= count_d;
        end
    end

`ifdef PLAB5_MCORE_MEM_REQ_CMSG_UNPACK_SCRUB_EN
    assign w_head = out_val ? entry_q[deq_ptr_q] : '0;
`else
    assign w_head = entry_q[deq_ptr_q];
`endif

    assign out_domain = w_head[c_MSG_NBITS];
    assign out_type   = w_head[c_MSG_NBITS-1 -: c_TYPE_NBITS];
    assign out_opaque = w_head[c_LEN_NBITS + p_addr_nbits +: p_opaque_nbits];
    assign out_addr   = w_head[c_LEN_NBITS +: p_addr_nbits];
    assign out_len    = w_head[0 +: c_LEN_NBITS];

    // A zero length encodes a full data word; masked outputs stay all-zero.
`ifdef PLAB5_MCORE_MEM_REQ_CMSG_UNPACK_SCRUB_EN
    assign out_nbytes = !out_val ? '0 :
                        (out_len == '0) ? c_NBYTES_FULL : {1'b0, out_len};
`else
    assign out_nbytes = (out_len == '0) ? c_NBYTES_FULL : {1'b0, out_len};
`endif

endmodule
`default_nettype wire

// File: tb/tb_plab5_mcore_mem_req_cmsg_unpack.sv
`default_nettype none
// Testbench for plab5_mcore_mem_req_cmsg_unpack: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_plab5_mcore_mem_req_cmsg_unpack;

    localparam int O   = 8;
    localparam int A   = 32;
    localparam int D   = 32;
    localparam int L   = 2;
    localparam int C   = 3 + O + A + L;
    localparam int L64 = 3;
    localparam int C64 = 3 + O + A + L64;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic           in_domain = 1'b0;
    logic [C-1:0]   in_msg    = '0;
    logic           in_val    = 1'b0;
    logic           in_rdy;
    logic           out_domain;
    logic [2:0]     out_type;
    logic [O-1:0]   out_opaque;
    logic [A-1:0]   out_addr;
    logic [L-1:0]   out_len;
    logic [L:0]     out_nbytes;
    logic           out_val;
    logic           out_rdy   = 1'b0;

    logic           in_domain64 = 1'b0;
    logic [C64-1:0] in_msg64    = '0;
    logic           in_val64    = 1'b0;
    logic           in_rdy64;
    logic           out_domain64;
    logic [2:0]     out_type64;
    logic [O-1:0]   out_opaque64;
    logic [A-1:0]   out_addr64;
    logic [L64-1:0] out_len64;
    logic [L64:0]   out_nbytes64;
    logic           out_val64;
    logic           out_rdy64   = 1'b1;

    plab5_mcore_mem_req_cmsg_unpack #(.p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D)) dut (
        .clk(clk), .reset(reset), .in_domain(in_domain), .in_msg(in_msg), .in_val(in_val),
        .in_rdy(in_rdy), .out_domain(out_domain), .out_type(out_type), .out_opaque(out_opaque),
        .out_addr(out_addr), .out_len(out_len), .out_nbytes(out_nbytes), .out_val(out_val),
        .out_rdy(out_rdy)
    );

    plab5_mcore_mem_req_cmsg_unpack #(.p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(64)) dut64 (
        .clk(clk), .reset(reset), .in_domain(in_domain64), .in_msg(in_msg64), .in_val(in_val64),
        .in_rdy(in_rdy64), .out_domain(out_domain64), .out_type(out_type64),
        .out_opaque(out_opaque64), .out_addr(out_addr64), .out_len(out_len64),
        .out_nbytes(out_nbytes64), .out_val(out_val64), .out_rdy(out_rdy64)
    );

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [C-1:0] pack(input int t, input int op, input logic [31:0] ad, input int ln);
        logic [C-1:0] m;
        m = C'(t);
        m = (m << O) | C'(op);
        m = (m << A) | C'(ad);
        m = (m << L) | C'(ln);
        return m;
    endfunction

    // Reference model: an ordered list of {domain, msg}, capacity two.
    logic [C:0] q[$];
    logic       m_enq, m_deq;

    always @(negedge reset) q.delete();

    always @(posedge clk) begin
        if (reset) begin
            m_enq = in_val && (q.size() < 2);
            m_deq = out_rdy && (q.size() > 0);
            if (m_deq) void'(q.pop_front());
            if (m_enq) q.push_back({in_domain, in_msg});
        end
    end

    logic [C:0]   e;
    logic [C-1:0] m;
    logic [63:0]  exp_len;

    always @(negedge clk) begin
        check("out_val", out_val, q.size() != 0);
        check("in_rdy", in_rdy, reset && (q.size() < 2));
        if (q.size() != 0) begin
            e = q[0];
            m = e[C-1:0];
            exp_len = 64'(m % (1 << L));
            check("out_domain", out_domain, e[C]);
            check("out_type", out_type, 64'(m >> (C - 3)));
            check("out_opaque", out_opaque, 64'((m >> (L + A)) % (1 << O)));
            check("out_addr", out_addr, 64'((m >> L) % (64'd1 << A)));
            check("out_len", out_len, exp_len);
            check("out_nbytes", out_nbytes, (exp_len == 0) ? 64'(D / 8) : exp_len);
        end
`ifdef PLAB5_MCORE_MEM_REQ_CMSG_UNPACK_SCRUB_EN
        else begin
            check("idle_addr", out_addr, 0);
            check("idle_domain", out_domain, 0);
            check("idle_nbytes", out_nbytes, 0);
        end
`endif
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_out_val", out_val, 0);
        check("rst_in_rdy", in_rdy, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_domain", out_domain, 0);
        step();
        reset = 1'b1;
        #1;
        check("post_rst_in_rdy", in_rdy, 1);

        // Single message
        in_val = 1; in_domain = 1; in_msg = pack(1, 8'h5A, 32'h0000_1000, 2);
        step();
        in_val = 0;
        check("t1_val", out_val, 1);
        check("t1_type", out_type, 1);
        check("t1_opaque", out_opaque, 8'h5A);
        check("t1_addr", out_addr, 32'h1000);
        check("t1_len", out_len, 2);
        check("t1_nbytes", out_nbytes, 2);
        check("t1_domain", out_domain, 1);
        out_rdy = 1; step(); out_rdy = 0;

        // Fill and backpressure
        in_val = 1; in_domain = 0; in_msg = pack(2, 8'hA0, 32'hA, 1); step();
        in_domain = 1; in_msg = pack(3, 8'hB0, 32'hB, 3); step();
        check("full_in_rdy", in_rdy, 0);
        in_domain = 0; in_msg = pack(4, 8'hC0, 32'hC, 0);
        repeat (3) step();
        check("full_still_A", out_addr, 32'hA);
        out_rdy = 1; step();
        check("drain_B", out_addr, 32'hB);
        step(); in_val = 0;
        check("drain_C", out_addr, 32'hC);
        check("drain_C_nbytes", out_nbytes, 4);
        step();
        check("drained", out_val, 0);

        // Streaming
        in_val = 1; out_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            in_domain = 1'($urandom);
            in_msg = pack(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), 32'h100 + i,
                          int'($urandom_range(0, 3)));
            check("stream_in_rdy", in_rdy, 1);
            step();
            check("stream_addr", out_addr, 32'h100 + i);
        end
        in_val = 0; step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            in_val = 1'($urandom); out_rdy = 1'($urandom); in_domain = 1'($urandom);
            in_msg = pack(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)), $urandom,
                          int'($urandom_range(0, 3)));
            step();
        end
        in_val = 0; out_rdy = 1; repeat (3) step();

        // Wide data word: len 0 decodes to 8 bytes
        in_val64 = 1; in_msg64 = {3'd1, 8'h11, 32'h2000, 3'd0}; step(); in_val64 = 0;
        check("d64_val", out_val64, 1);
        check("d64_nbytes", out_nbytes64, 8);
        step();

        // Mid-operation reset
        out_rdy = 0; in_val = 1; in_domain = 1;
        in_msg = pack(5, 8'h55, 32'hDEAD, 1); step();
        in_msg = pack(6, 8'h66, 32'hBEEF, 2); step(); in_val = 0;
        @(negedge clk); #2;
        reset = 0; #1;
        check("mr_out_val", out_val, 0);
        check("mr_in_rdy", in_rdy, 0);
        check("mr_out_addr", out_addr, 0);
        @(posedge clk); #1; reset = 1;
        in_val = 1; in_domain = 0; in_msg = pack(7, 8'h77, 32'h1234_5678, 3); step(); in_val = 0;
        check("mr_new_addr", out_addr, 32'h1234_5678);
        check("mr_new_type", out_type, 7);
        check("mr_new_opaque", out_opaque, 8'h77);
        out_rdy = 1; step();

        // Stale-data visibility after both entries drain
        out_rdy = 0; in_val = 1; in_domain = 1; in_msg = pack(1, 8'hFF, 32'hFFFF_FFFF, 1);
        step(); step(); in_val = 0;
        out_rdy = 1; step(); step(); out_rdy = 0;
        check("idle_out_val", out_val, 0);
`ifdef PLAB5_MCORE_MEM_REQ_CMSG_UNPACK_SCRUB_EN
        check("scrub_addr", out_addr, 0);
        check("scrub_domain", out_domain, 0);
`else
        check("stale_addr", out_addr, 32'hFFFF_FFFF);
        check("stale_domain", out_domain, 1);
`endif
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plab5_mcore_mem_req_cmsg_unpack.md
# plab5_mcore_mem_req_cmsg_unpack

Receive-side counterpart of the memory request control-message packer. Accepts packed control messages (type, opaque, addr, len) on a val/rdy interface, buffers them in a 2-entry queue together with their security domain tag, and presents the unpacked fields plus a decoded byte count on a val/rdy output interface. It sits between the memory-request network port and the cache/memory request-control datapath.

## Interface
Parameters:
- p_opaque_nbits, 8, opaque field width (o)
- p_addr_nbits, 32, address field width (a)
- p_data_nbits, 32, data width (d); must be a power of two and at least 16
- Derived values, not overridable: t = 3 (type width); l = clog2(d/8) (len width); c = t+o+a+l (45 with defaults)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low
- in_domain  in  1  security domain of the incoming message
- in_msg  in  c  packed control message
- in_val  in  1  input valid
- in_rdy  out  1  input ready
- out_domain  out  1  domain tag of the head entry
- out_type  out  3  head entry, in_msg[c-1:l+a+o]
- out_opaque  out  o  head entry, in_msg[l+a+o-1:l+a]
- out_addr  out  a  head entry, in_msg[l+a-1:l]
- out_len  out  l  head entry, in_msg[l-1:0]
- out_nbytes  out  l+1  decoded byte count: len==0 gives d/8, otherwise len
- out_val  out  1  output valid
- out_rdy  in  1  output ready

## Operation
- Storage: 2 entries, each holding {domain, c-bit msg}. State: enq_ptr (1b), deq_ptr (1b), count (2b, range 0..2).
- Enqueue fires when in_val && in_rdy. It writes the entry at enq_ptr, then enq_ptr toggles.
- Dequeue fires when out_val && out_rdy. deq_ptr toggles.
- in_rdy = (count != 2) && reset deasserted.
- out_val = (count != 0).
- count update: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither fire.
- No bypass path. A message is never visible on the output in the same cycle it is accepted.
- Output fields come combinationally from the entry at deq_ptr. The field slicing is the exact inverse of the packer layout: type, then opaque, then addr, then len, from MSB to LSB.
- out_nbytes is computed combinationally from out_len. With d=32: len 0→4, 1→1, 2→2, 3→3.
- The domain tag travels with its entry and is never merged or altered.
- in_msg and in_domain are ignored when the enqueue does not fire.

## Timing
- Reset assertion (reset low), any cycle, asynchronous:
  - count, enq_ptr and deq_ptr go to 0.
  - Both storage entries are cleared to 0.
  - out_val=0 and in_rdy=0; all field outputs and out_domain are 0.
  - An in-flight handshake in that cycle is dropped.
- First edge after reset goes high: in_rdy=1.
- Latency from enqueue edge to out_val=1 is 1 cycle.
- Throughput: 1 message per cycle in steady state.
  - count==1: simultaneous enqueue and dequeue are both allowed.
  - count==2: in_rdy=0, so a full queue cannot accept and drain in the same cycle.
- Pointer wrap-around: each pointer is 1 bit and wraps naturally from 1 to 0. Order is strictly FIFO.
- Outputs hold stable while out_val && !out_rdy.

## Configuration
- PLAB5_MCORE_MEM_REQ_CMSG_UNPACK_SCRUB_EN
- Defined:
  - The entry being dequeued is cleared to 0, including its domain bit, on the dequeue edge, unless it is simultaneously being re-written by an enqueue.
  - All field outputs, out_nbytes and out_domain are forced to 0 whenever out_val=0.
  - This prevents stale high-domain data from staying visible.
- Undefined:
  - Entries keep their stale contents after dequeue.
  - Field outputs show the entry at deq_ptr even when out_val=0.
- Handshake behaviour is identical in both builds.

## Test plan
- Reset then single message: in_msg with type=1, opaque=0x5A, addr=0x00001000, len=2, domain=1, in_val for 1 cycle -> next cycle out_val=1, out_type=1, out_opaque=0x5A, out_addr=0x1000, out_len=2, out_nbytes=2, out_domain=1.
- Fill and backpressure: out_rdy=0, enqueue A then B -> in_rdy=0 after B. Offer C for 3 cycles and it is not accepted. Raise out_rdy -> A, B, C dequeue in order on consecutive cycles.
- Streaming: in_val=out_rdy=1 for 20 messages with incrementing addr -> one output per cycle after a 1-cycle latency, all in order. Pointer wrap is exercised 10 times; count never exceeds 1.
- len decode: len=0 with d=32 -> out_nbytes=4. Repeat with p_data_nbits=64, len=0 -> out_nbytes=8.
- Mid-operation reset: two entries queued, pull reset low between edges -> out_val and in_rdy drop to 0 immediately. After release the queue is empty and the first new message comes out uncorrupted.
- Scrub (macro defined): enqueue domain=1, addr=0xFFFFFFFF, then dequeue -> out_val=0 with out_addr=0 and out_domain=0, and the stored entry reads 0. Without the macro, out_addr stays 0xFFFFFFFF.
